// File: rtl/datamem_pkg.sv
// Shared types and sizing for the data-memory arbiter.
package datamem_pkg;

    localparam int DATAMEM_DEPTH  = 128;
    localparam int DATAMEM_ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        port;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances past each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = rr_ptr ? 2'b10 : 2'b01;
    end

    // Granting port 0 hands priority to port 1 and vice versa.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    rr_ptr <= 1'b0;
        else if (update) rr_ptr <= gnt[0];
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-port data memory, one access in flight.
// Optional DATAMEM_ADDR_CHECK_EN adds misaligned/out-of-range address faulting (rsp*_err).
//
// state | meaning
// IDLE  | waiting for a request; grants one via round-robin
// ISSUE | mem_en strobe for the captured access
// WAIT  | counting down memory latency, samples mem_rdata at zero
// RESP  | one-cycle response pulse on the owning port
module datamem_arbiter
    import datamem_pkg::*;
#(
    parameter int DEPTH   = DATAMEM_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [31:0]       req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [31:0]       req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              rsp0_valid,
    output logic [31:0]       rsp0_rdata,
    output logic              rsp1_valid,
    output logic [31:0]       rsp1_rdata,
`ifdef DATAMEM_ADDR_CHECK_EN
    output logic              rsp0_err,
    output logic              rsp1_err,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);

    state_e           state;
    mem_req_t         req_q;
    mem_req_t         req_in;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       valid;
    logic [1:0]       gnt;
    logic             idle;
    logic             accept;
    logic             skip_issue;
    logic             resp_zero;

    assign idle   = (state == IDLE);
    assign valid  = {req1_valid, req0_valid};
    assign accept = idle && (valid != 2'b00);

    // Ready is held low while reset is asserted even though the state reads IDLE.
    assign req0_ready = reset_n && idle && gnt[0];
    assign req1_ready = reset_n && idle && gnt[1];

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (valid),
        .update  (accept),
        .gnt     (gnt)
    );

    always_comb begin
        req_in.port  = gnt[1];
        req_in.we    = gnt[1] ? req1_we    : req0_we;
        req_in.addr  = gnt[1] ? req1_addr  : req0_addr;
        req_in.wdata = gnt[1] ? req1_wdata : req0_wdata;
    end

    assign mem_we    = mem_en && req_q.we;
    assign mem_addr  = mem_en ? req_q.addr[ADDR_W+1:2] : '0;
    assign mem_wdata = mem_en ? req_q.wdata : '0;

`ifdef DATAMEM_ADDR_CHECK_EN
    logic err_q;
    assign skip_issue = (req_in.addr[1:0] != 2'b00) || (req_in.addr[31:ADDR_W+2] != '0);
    assign resp_zero  = req_q.we || err_q;
`else
    logic unused_addr_bits;
    assign skip_issue       = 1'b0;
    assign resp_zero        = req_q.we;
    assign unused_addr_bits = ^{req_q.addr[31:ADDR_W+2], req_q.addr[1:0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_q      <= '0;
            lat_cnt    <= '0;
            mem_en     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
`ifdef DATAMEM_ADDR_CHECK_EN
            err_q      <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= req_in;
`ifdef DATAMEM_ADDR_CHECK_EN
                        err_q <= skip_issue;
`endif
                        // A faulting request spends the ISSUE cycle in WAIT so latency matches.
                        if (skip_issue) begin
                            lat_cnt <= LAT_W'(MEM_LAT);
                            state   <= WAIT;
                        end else begin
                            mem_en  <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp0_valid <= !req_q.port;
                        rsp1_valid <= req_q.port;
                        rsp0_rdata <= (!req_q.port && !resp_zero) ? mem_rdata : '0;
                        rsp1_rdata <= (req_q.port && !resp_zero) ? mem_rdata : '0;
`ifdef DATAMEM_ADDR_CHECK_EN
                        rsp0_err   <= !req_q.port && err_q;
                        rsp1_err   <= req_q.port && err_q;
`endif
                        state      <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp0_rdata <= '0;
                    rsp1_rdata <= '0;
`ifdef DATAMEM_ADDR_CHECK_EN
                    rsp0_err   <= 1'b0;
                    rsp1_err   <= 1'b0;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance, behavioural memories.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DATAMEM_ADDR_CHECK_EN
    logic        rsp0_err, rsp1_err, b_rsp0_err, b_rsp1_err;
`endif

    logic        b_req0_valid, b_req0_ready, b_req0_we;
    logic [31:0] b_req0_addr, b_req0_wdata;
    logic        b_req1_valid, b_req1_ready, b_req1_we;
    logic [31:0] b_req1_addr, b_req1_wdata;
    logic        b_rsp0_valid, b_rsp1_valid;
    logic [31:0] b_rsp0_rdata, b_rsp1_rdata;
    logic        b_mem_en, b_mem_we;
    logic [6:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    datamem_arbiter #(.MEM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
`ifdef DATAMEM_ADDR_CHECK_EN
        .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    datamem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
`ifdef DATAMEM_ADDR_CHECK_EN
        .rsp0_err(b_rsp0_err), .rsp1_err(b_rsp1_err),
`endif
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Behavioural memories: latency 1 and a 3-stage read pipeline.
    logic [31:0] mem  [128];
    logic [31:0] mem3 [128];
    logic [31:0] pipe3 [3];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en && b_mem_we) mem3[b_mem_addr] <= b_mem_wdata;
        pipe3[0] <= (b_mem_en && !b_mem_we) ? mem3[b_mem_addr] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign b_mem_rdata = pipe3[2];

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req0_valid = !port; req1_valid = port;
        if (port) begin req1_we = we; req1_addr = addr; req1_wdata = wdata; end
        else      begin req0_we = we; req0_addr = addr; req0_wdata = wdata; end
    endtask

    task automatic access(input vec_t v, input string tag);
        logic [1:0] pm;
        pm = v.port ? 2'b10 : 2'b01;
        @(negedge clk);
        drive(v.port, v.we, v.addr, v.wdata);
        #1;
        chk({tag, " ready"}, {30'b0, req1_ready, req0_ready}, {30'b0, pm});
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, " mem_en"}, {31'b0, mem_en}, 32'd1);
        chk({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, v.we});
        chk({tag, " mem_addr"}, {25'b0, mem_addr}, {25'b0, v.exp_maddr});
        chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
        @(negedge clk);
        chk({tag, " idle mem"}, {31'b0, mem_en}, 32'd0);
        chk({tag, " early rsp"}, {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        @(negedge clk);
        chk({tag, " rsp"}, {30'b0, rsp1_valid, rsp0_valid}, {30'b0, pm});
        chk({tag, " rdata"}, v.port ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
        chk({tag, " other rdata"}, v.port ? rsp0_rdata : rsp1_rdata, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic access3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input string tag);
        @(negedge clk);
        b_req0_valid = 1'b1; b_req0_we = we; b_req0_addr = addr; b_req0_wdata = wdata;
        #1;
        chk({tag, " ready"}, {31'b0, b_req0_ready}, 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("%s c%0d ready", tag, c), {31'b0, b_req0_ready}, 32'd0);
            chk($sformatf("%s c%0d mem_en", tag, c), {31'b0, b_mem_en}, (c == 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s c%0d rsp", tag, c), {31'b0, b_rsp0_valid}, (c == 5) ? 32'd1 : 32'd0);
            if (c == 1) chk({tag, " mem_addr"}, {25'b0, b_mem_addr}, {25'b0, addr[8:2]});
            if (c == 5) begin
                chk({tag, " rdata"}, b_rsp0_rdata, exp_rdata);
                chk({tag, " port1 quiet"}, {30'b0, b_req1_ready, b_rsp1_valid}, 32'd0);
                chk({tag, " port1 rdata"}, b_rsp1_rdata, 32'd0);
                b_req0_valid = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1111_1111, 7'd0,   32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 7'd4,   32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         7'd4,   32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         7'd0,   32'h1111_1111};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_01FC, 32'hA5A5_A5A5, 7'd127, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_01FC, 32'h0,         7'd127, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         7'd4,   32'hDEAD_BEEF};

        reset_n = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        b_req0_valid = 0; b_req0_we = 0; b_req0_addr = 0; b_req0_wdata = 0;
        b_req1_valid = 0; b_req1_we = 0; b_req1_addr = 0; b_req1_wdata = 0;
        #1;
        chk("reset ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("reset rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("reset rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        chk("reset mem", {mem_wdata[31:9], mem_addr, mem_we, mem_en}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Port 1 alone with rr_ptr=0, then the write/read-back table.
        for (int i = 0; i < 7; i++) access(vecs[i], $sformatf("vec%0d", i));

        // Both ports continuously valid from reset: grants alternate 0,1,0,1.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0;
        for (int c = 0; c < 16; c++) begin
            int ph, pt;
            ph = c % 4;
            pt = (c / 4) % 2;
            #1;
            chk($sformatf("rr c%0d ready", c), {30'b0, req1_ready, req0_ready},
                (ph == 0) ? ((pt == 1) ? 32'd2 : 32'd1) : 32'd0);
            chk($sformatf("rr c%0d rsp", c), {30'b0, rsp1_valid, rsp0_valid},
                (ph == 3) ? ((pt == 1) ? 32'd2 : 32'd1) : 32'd0);
            if (ph == 3)
                chk($sformatf("rr c%0d rdata", c), (pt == 1) ? rsp1_rdata : rsp0_rdata,
                    (pt == 1) ? 32'h1111_1111 : 32'hDEAD_BEEF);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Write past the top of memory.
`ifdef DATAMEM_ADDR_CHECK_EN
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h200, 32'h0BAD_F00D);
        #1;
        chk("wrap ready", {30'b0, req1_ready, req0_ready}, 32'd2);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req1_valid = 1'b0;
            chk($sformatf("err c%0d mem_en", c), {31'b0, mem_en}, 32'd0);
        end
        chk("err rsp", {29'b0, rsp1_err, rsp1_valid, rsp0_valid}, 32'd6);
        chk("err rdata", rsp1_rdata, 32'd0);
        chk("err mem0", mem[0], 32'h1111_1111);
`else
        access('{1'b1, 1'b1, 32'h200, 32'h0BAD_F00D, 7'd0, 32'h0}, "wrap wr");
        access('{1'b0, 1'b0, 32'h0,   32'h0,         7'd0, 32'h0BAD_F00D}, "wrap rd");
`endif

        // Reset during WAIT abandons the access; pointer returns to port 0.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        #1;
        chk("rst acc ready", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst outputs", {28'b0, req1_ready, req0_ready, mem_en, rsp0_valid}, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst hold%0d", c), {28'b0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);
        end
        reset_n = 1'b1;
        #1;
        chk("post rst grant", {30'b0, req1_ready, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post rst rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("post rst rdata", rsp0_rdata, 32'hDEAD_BEEF);

        // MEM_LAT=3 instance.
        access3(1'b1, 32'h8, 32'h1234_5678, 32'h0, "lat3 wr");
        access3(1'b0, 32'h8, 32'h0, 32'h1234_5678, "lat3 rd");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
